// File: rtl/mi_fetch_queue.sv
// mi_fetch_queue: two-issue fetch front end. Issues packet fetches to
// instruction memory, buffers {pc, packet} responses in a small FIFO and
// hands them to decode. A redirect flushes buffered and in-flight fetches;
// a halt instruction stops fetching until the next redirect.
module mi_fetch_queue #(
  parameter logic [31:0] PC_START = 32'h8000_0000,
  parameter int ISSUE_NUM = 2,
  parameter int INST_DW   = 32,
  parameter int INST_AW   = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(DEPTH+1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_en_i,
  input  logic [INST_AW-1:0]           redirect_pc_i,
  output logic                         inst_en_o,
  output logic [INST_AW-1:0]           inst_addr_o,
  input  logic [INST_DW*ISSUE_NUM-1:0] inst_i,
  output logic                         deq_valid_o,
  input  logic                         deq_ready_i,
  output logic [INST_AW-1:0]           deq_pc_o,
  output logic [INST_DW*ISSUE_NUM-1:0] deq_inst_o,
  output logic                         halted_o,
  output logic [CNT_W-1:0]             count_o
);

  localparam int PW    = INST_DW * ISSUE_NUM;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [INST_DW-1:0] HALT_INST = INST_DW'(32'h0000_006b);

  typedef struct packed {
    logic [INST_AW-1:0] pc;
    logic [PW-1:0]      pkt;
  } entry_t;

  logic [INST_AW-1:0] fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [INST_AW-1:0] inflight_pc_q, inflight_pc_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];

  logic req, enq, deq, halt_hit;
  logic [CNT_W:0] occ;

  // Request gate, enqueue/dequeue strobes. The in-flight fetch reserves a
  // slot so a response always has room (memory cannot be stalled).
  always_comb begin
    occ      = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q);
    req      = !rst && !redirect_en_i && !halted_q && (occ < (CNT_W+1)'(DEPTH));
    enq      = inflight_q && !redirect_en_i;
    deq_valid_o = (count_q != '0) && !redirect_en_i;
    deq      = deq_valid_o && deq_ready_i;
    halt_hit = enq && (inst_i[INST_DW-1:0] == HALT_INST);
  end

  // Next-state: fetch PC, in-flight tracking, FIFO bookkeeping and halt.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = req;
    inflight_pc_d = inflight_pc_q;
    halted_d      = halted_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    mem_d         = mem_q;
    if (redirect_en_i) begin
      // Flush: any response landing now or next cycle is dropped because
      // inflight is cleared and no request goes out this cycle.
      fetch_pc_d = redirect_pc_i;
      halted_d   = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req) begin
        fetch_pc_d    = fetch_pc_q + INST_AW'(4 * ISSUE_NUM);
        inflight_pc_d = fetch_pc_q;
      end
      if (enq) begin
        mem_d[wr_ptr_q] = '{pc: inflight_pc_q, pkt: inst_i};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
      halted_d = halted_q || halt_hit;
    end
  end

  // State registers; storage is cleared too so head outputs read zero in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= INST_AW'(PC_START);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      halted_q      <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      mem_q         <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      halted_q      <= halted_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      mem_q         <= mem_d;
    end
  end

  // Output mapping.
  always_comb begin
    inst_en_o   = req;
    inst_addr_o = fetch_pc_q;
    deq_pc_o    = mem_q[rd_ptr_q].pc;
    deq_inst_o  = mem_q[rd_ptr_q].pkt;
    halted_o    = halted_q;
    count_o     = count_q;
  end

endmodule

// File: doc/mi_fetch_queue.md
Name: mi_fetch_queue

Overview:
- Two-issue instruction fetch front end. Issues 64-bit fetch requests (two instructions per request) to instruction memory.
- Buffers the returned instruction pairs, with their PCs, in a small FIFO and hands them to the decode stage with a valid/ready handshake.
- Sits upstream of the scalar/vector decoders. Accepts a PC redirect from the scalar ALU, which flushes all buffered and in-flight fetches.

Parameters:
- PC_START, 32'h8000_0000, PC of the first fetch after reset
- ISSUE_NUM, 2, instructions per fetch packet
- INST_DW, 32, instruction width
- INST_AW, 32, address width
- DEPTH, 4, FIFO entries (power of two, >= 2)
- CNT_W, $clog2(DEPTH+1), width of count_o

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect_en_i  in  1  taken branch/jump this cycle
- redirect_pc_i  in  INST_AW  redirect target
- inst_en_o  out  1  fetch request strobe
- inst_addr_o  out  INST_AW  fetch address
- inst_i  in  INST_DW*ISSUE_NUM  fetch data, valid exactly 1 cycle after the request
- deq_valid_o  out  1  head entry valid
- deq_ready_i  in  1  decode accepts head
- deq_pc_o  out  INST_AW  PC of slot 0 of head entry
- deq_inst_o  out  INST_DW*ISSUE_NUM  head packet; slot 0 in [31:0], slot 1 in [63:32]
- halted_o  out  1  halt instruction enqueued; fetch stopped
- count_o  out  CNT_W  current FIFO occupancy

Behaviour:
- Reset: clk and rst as named; rst is asynchronous and active-high.
  - State reset values: fetch_pc=PC_START, count=0, rd/wr pointers=0, inflight=0, halted=0.
  - Outputs during reset: inst_en_o=0, deq_valid_o=0, halted_o=0, count_o=0, deq_pc_o=0, deq_inst_o=0.
  - Reset mid-operation discards everything immediately.
- State: fetch_pc, inflight flag, inflight_pc, DEPTH-entry FIFO of {pc, packet}, halted flag.
- Request rule (combinational):
  - inst_en_o = !rst & !redirect_en_i & !halted & (count + inflight < DEPTH).
  - inst_addr_o = fetch_pc.
  - On a request: fetch_pc <= fetch_pc + 4*ISSUE_NUM (+8, wraps modulo 2^INST_AW), inflight <= 1, inflight_pc <= fetch_pc.
  - Otherwise inflight <= 0.
  - The occupancy gate counts the in-flight slot, so the FIFO never overflows. No back-pressure exists toward memory.
- Response:
  - If inflight=1 and there is no redirect this cycle, write {inflight_pc, inst_i} at wr_ptr.
  - The FIFO has no bypass. Request at cycle t, data at t+1, deq_valid_o at t+2.
- Dequeue:
  - deq_valid_o = (count != 0) & !redirect_en_i.
  - A fire (deq_valid_o & deq_ready_i) advances rd_ptr.
  - deq_pc_o and deq_inst_o hold the head entry and stay stable while valid and not ready.
- Simultaneous enqueue and dequeue: count is unchanged. The pointers wrap modulo DEPTH.
- Redirect (redirect_en_i=1):
  - No request and no dequeue in that cycle.
  - Next state: count=0, pointers equal, inflight=0 (any response arriving in this or the next cycle is dropped), halted=0, fetch_pc=redirect_pc_i.
  - The first request at the redirect target is issued the following cycle.
  - redirect_pc_i is passed through unmodified; packet alignment is the memory's concern.
- Halt:
  - When an enqueued packet has slot 0 == 32'h0000006b, set halted in the same cycle as the enqueue.
  - Further requests stop; already buffered entries still drain.
  - Only a redirect or reset clears halted.
  - halted_o mirrors the halted flag.
- count_o = number of valid FIFO entries.

Test Plan:
- Reset release, deq_ready_i=1, memory returns pattern {pc+4, pc}:
  - inst_en_o=1 at cycle 0 with addr 0x8000_0000, then 0x8000_0008, 0x8000_0010.
  - First deq_valid_o at cycle 2 with deq_pc_o=0x8000_0000.
  - Thereafter one packet per cycle, PCs strictly +8.
- Back-pressure, deq_ready_i=0, DEPTH=4:
  - Exactly 4 requests are issued, then inst_en_o=0 and count_o=4.
  - The head holds 0x8000_0000 stable.
  - Raising ready for one cycle pops it and restarts fetch at 0x8000_0020.
- Redirect to 0x8000_0100 while count=3 and a fetch is in flight:
  - Redirect cycle: deq_valid_o=0, inst_en_o=0.
  - Next cycle: count_o=0 and a request at 0x8000_0100.
  - The stale response is not enqueued.
  - First dequeued PC after the redirect is 0x8000_0100.
- Halt, with memory returning slot 0=0x0000006b at 0x8000_0010:
  - halted_o=1 on enqueue and no further inst_en_o.
  - Entries 0x8000_0000..0x8000_0010 dequeue in order.
  - A later redirect to 0x8000_0000 clears halted and resumes fetch.
- Asynchronous rst asserted mid-stream (count=2, inflight=1), between clock edges:
  - All outputs go to reset values immediately.
  - After release, the first request is again at 0x8000_0000.
- Simultaneous enqueue and dequeue at count=2 for 10 cycles:
  - count_o stays at 2.
  - Pointers wrap, and PC order continues at +8 with no loss or duplication.
